// File: rtl/tsu_queue_mc.sv
// rtl/tsu_queue_mc.sv - multi-channel timestamp capture queue with a shared register-side read port
// Each channel is a circular FIFO of {tag, time}; pops are registered for 1-cycle read latency.
module tsu_queue_mc #(
  parameter int CH       = 2,
  parameter int DEPTH    = 16,
  parameter int TS_W     = 64,
  parameter int OVF_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TS_W-1:0]      rtc_time_in,
  input  logic [CH-1:0]        cap_valid_in,
  input  logic [16*CH-1:0]     cap_tag_in,
  input  logic [2:0]           rd_ch_in,
  input  logic                 rd_en_in,
  output logic [TS_W+15:0]     rd_data_out,
  output logic                 rd_valid_out,
  output logic [8*CH-1:0]      stat_out,
  input  logic [CH-1:0]        ovf_clr_in,
  input  logic [CH-1:0]        irq_en_in,
  output logic                 irq_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TS_W + 16;

  logic [EW-1:0] mem_q [CH][DEPTH];
  logic [EW-1:0] wdata [CH];
  logic [AW-1:0] wp_q [CH];
  logic [AW-1:0] wp_d [CH];
  logic [AW-1:0] rp_q [CH];
  logic [AW-1:0] rp_d [CH];
  logic [CW-1:0] cnt_q [CH];
  logic [CW-1:0] cnt_d [CH];
  logic [CH-1:0] ovf_q, ovf_d, we, pop;
  logic [EW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          irq_q, irq_d;
  logic          full;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    irq_d      = 1'b0;
    ovf_d      = ovf_q;
    we         = '0;
    pop        = '0;
    full       = 1'b0;
    for (int i = 0; i < CH; i++) begin
      wp_d[i]  = wp_q[i];
      rp_d[i]  = rp_q[i];
      cnt_d[i] = cnt_q[i];
      wdata[i] = {cap_tag_in[16*i +: 16], rtc_time_in};
      pop[i]   = rd_en_in && (32'(rd_ch_in) == i) && (cnt_q[i] != '0);
      full     = (cnt_q[i] == CW'(DEPTH));
      if (ovf_clr_in[i]) ovf_d[i] = 1'b0;
      if (pop[i]) begin
        rd_data_d  = mem_q[i][rp_q[i]];
        rd_valid_d = 1'b1;
        rp_d[i]    = rp_q[i] + AW'(1);
      end
      // A pop in the same cycle frees the slot, so a full channel still accepts the push.
      if (cap_valid_in[i]) begin
        if (pop[i] || !full) begin
          we[i]   = 1'b1;
          wp_d[i] = wp_q[i] + AW'(1);
          if (!pop[i]) cnt_d[i] = cnt_q[i] + CW'(1);
        end else begin
          ovf_d[i] = 1'b1;
          if (OVF_MODE == 1) begin
            we[i]   = 1'b1;
            wp_d[i] = wp_q[i] + AW'(1);
            rp_d[i] = rp_q[i] + AW'(1);
          end
        end
      end else if (pop[i]) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
      irq_d = irq_d | (irq_en_in[i] && (cnt_d[i] != '0));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      ovf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        wp_q[i]  <= wp_d[i];
        rp_q[i]  <= rp_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (we[i]) mem_q[i][wp_q[i]] <= wdata[i];
    end
  end

  always_comb begin
    stat_out = '0;
    for (int i = 0; i < CH; i++) begin
      stat_out[8*i +: 8] = {ovf_q[i], 1'b0, 6'(cnt_q[i])};
    end
  end

  assign rd_data_out  = rd_data_q;
  assign rd_valid_out = rd_valid_q;
  assign irq_out      = irq_q;

endmodule

// File: tb/tb_tsu_queue_mc.sv
// tb/tb_tsu_queue_mc.sv - self-checking bench for tsu_queue_mc (CH=2, DEPTH=4, both overflow policies)
module tb_tsu_queue_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] rtc;
  logic [1:0]  cap;
  logic [31:0] tag;
  logic [2:0]  rd_ch;
  logic        rd_en;
  logic [1:0]  ovf_clr;
  logic [1:0]  irq_en;
  logic [79:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1;
  logic [15:0] stat0, stat1;
  logic        irq0, irq1;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [79:0] sb[$];

  always #5 clk = ~clk;

  tsu_queue_mc #(.CH(2), .DEPTH(4), .TS_W(64), .OVF_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .rtc_time_in(rtc), .cap_valid_in(cap), .cap_tag_in(tag),
    .rd_ch_in(rd_ch), .rd_en_in(rd_en), .rd_data_out(rd_data0), .rd_valid_out(rd_valid0),
    .stat_out(stat0), .ovf_clr_in(ovf_clr), .irq_en_in(irq_en), .irq_out(irq0));

  tsu_queue_mc #(.CH(2), .DEPTH(4), .TS_W(64), .OVF_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .rtc_time_in(rtc), .cap_valid_in(cap), .cap_tag_in(tag),
    .rd_ch_in(rd_ch), .rd_en_in(rd_en), .rd_data_out(rd_data1), .rd_valid_out(rd_valid1),
    .stat_out(stat1), .ovf_clr_in(ovf_clr), .irq_en_in(irq_en), .irq_out(irq1));

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Every pop accepted by dut0 must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && rd_valid0) begin
      if (sb.size() == 0) begin
        tot_cnt++;
        $display("FAIL sb_unexpected: got rd_valid_out=1 data %h expected no pop", rd_data0);
      end else begin
        chk("sb_pop", rd_data0, sb.pop_front());
      end
    end
  end

  task automatic step(input logic [1:0] c, input logic [15:0] t0, input logic [15:0] t1,
                      input logic [63:0] tm, input logic re, input logic [2:0] ch,
                      input logic [1:0] clr_v, input logic exp_pop, input logic [79:0] exp_d);
    cap = c; tag = {t1, t0}; rtc = tm; rd_en = re; rd_ch = ch; ovf_clr = clr_v;
    if (exp_pop) sb.push_back(exp_d);
    @(posedge clk);
    @(negedge clk);
    cap = '0; rd_en = 1'b0; ovf_clr = '0;
  endtask

  typedef struct {
    logic [1:0]  cap;
    logic [15:0] tag;
    logic [63:0] tm;
    logic        rd_en;
    logic [2:0]  rd_ch;
    logic        pop_ok;
    logic [15:0] etag;
    logic [63:0] etm;
    logic [15:0] exp_stat;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{2'b01, 16'd1, 64'd100, 1'b0, 3'd0, 1'b0, 16'd0, 64'd0,   16'h0001, 1'b1};
    vecs[1]  = '{2'b01, 16'd2, 64'd200, 1'b0, 3'd0, 1'b0, 16'd0, 64'd0,   16'h0002, 1'b1};
    vecs[2]  = '{2'b01, 16'd3, 64'd300, 1'b0, 3'd0, 1'b0, 16'd0, 64'd0,   16'h0003, 1'b1};
    vecs[3]  = '{2'b00, 16'd0, 64'd0,   1'b1, 3'd0, 1'b1, 16'd1, 64'd100, 16'h0002, 1'b1};
    vecs[4]  = '{2'b00, 16'd0, 64'd0,   1'b1, 3'd0, 1'b1, 16'd2, 64'd200, 16'h0001, 1'b1};
    vecs[5]  = '{2'b00, 16'd0, 64'd0,   1'b1, 3'd0, 1'b1, 16'd3, 64'd300, 16'h0000, 1'b0};
    vecs[6]  = '{2'b00, 16'd0, 64'd0,   1'b1, 3'd0, 1'b0, 16'd0, 64'd0,   16'h0000, 1'b0};
    vecs[7]  = '{2'b01, 16'd7, 64'd700, 1'b0, 3'd0, 1'b0, 16'd0, 64'd0,   16'h0001, 1'b1};
    vecs[8]  = '{2'b00, 16'd0, 64'd0,   1'b1, 3'd5, 1'b0, 16'd0, 64'd0,   16'h0001, 1'b1};
    vecs[9]  = '{2'b00, 16'd0, 64'd0,   1'b1, 3'd1, 1'b0, 16'd0, 64'd0,   16'h0001, 1'b1};
    vecs[10] = '{2'b01, 16'd8, 64'd800, 1'b1, 3'd0, 1'b1, 16'd7, 64'd700, 16'h0001, 1'b1};
    vecs[11] = '{2'b00, 16'd0, 64'd0,   1'b1, 3'd0, 1'b1, 16'd8, 64'd800, 16'h0000, 1'b0};
    vecs[12] = '{2'b01, 16'd9, 64'd900, 1'b1, 3'd0, 1'b0, 16'd0, 64'd0,   16'h0001, 1'b1};
    vecs[13] = '{2'b00, 16'd0, 64'd0,   1'b1, 3'd0, 1'b1, 16'd9, 64'd900, 16'h0000, 1'b0};

    rst = 1'b0; rtc = '0; cap = '0; tag = '0; rd_ch = '0; rd_en = 1'b0;
    ovf_clr = '0; irq_en = 2'b01;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_rd_data", rd_data0, 80'd0);
    chk("reset_rd_valid", 80'(rd_valid0), 80'd0);
    chk("reset_stat", 80'(stat0), 80'd0);
    chk("reset_irq", 80'(irq0), 80'd0);

    foreach (vecs[k]) begin
      step(vecs[k].cap, vecs[k].tag, vecs[k].tag, vecs[k].tm, vecs[k].rd_en, vecs[k].rd_ch,
           2'b00, vecs[k].pop_ok, {vecs[k].etag, vecs[k].etm});
      chk($sformatf("vec%0d_stat", k), 80'(stat0), 80'(vecs[k].exp_stat));
      chk($sformatf("vec%0d_irq", k), 80'(irq0), 80'(vecs[k].exp_irq));
      chk($sformatf("vec%0d_rd_valid", k), 80'(rd_valid0), 80'(vecs[k].pop_ok));
    end

    for (int k = 1; k <= 5; k++) step(2'b10, 16'd0, 16'(k), 64'(k * 10), 1'b0, 3'd0, 2'b00, 1'b0, 80'd0);
    chk("ovf0_stat_full", 80'(stat0[15:8]), 80'h84);
    chk("ovf1_stat_full", 80'(stat1[15:8]), 80'h84);
    for (int k = 1; k <= 4; k++) begin
      step(2'b00, 16'd0, 16'd0, 64'd0, 1'b1, 3'd1, 2'b00, 1'b1, {16'(k), 64'(k * 10)});
      chk($sformatf("ovf1_pop%0d_valid", k), 80'(rd_valid1), 80'd1);
      chk($sformatf("ovf1_pop%0d_data", k), rd_data1, {16'(k + 1), 64'((k + 1) * 10)});
    end
    chk("ovf0_stat_drained", 80'(stat0[15:8]), 80'h80);
    chk("ovf1_stat_drained", 80'(stat1[15:8]), 80'h80);
    step(2'b00, 16'd0, 16'd0, 64'd0, 1'b0, 3'd0, 2'b10, 1'b0, 80'd0);
    chk("ovf0_stat_clr", 80'(stat0[15:8]), 80'h00);
    chk("ovf1_stat_clr", 80'(stat1[15:8]), 80'h00);

    for (int k = 0; k < 4; k++) step(2'b01, 16'(11 + k), 16'd0, 64'(1000 + k), 1'b0, 3'd0, 2'b00, 1'b0, 80'd0);
    chk("full_stat_before", 80'(stat0[7:0]), 80'h04);
    step(2'b01, 16'd15, 16'd0, 64'd1004, 1'b1, 3'd0, 2'b00, 1'b1, {16'd11, 64'd1000});
    chk("full_pushpop_stat0", 80'(stat0[7:0]), 80'h04);
    chk("full_pushpop_stat1", 80'(stat1[7:0]), 80'h04);
    for (int k = 0; k < 4; k++) step(2'b00, 16'd0, 16'd0, 64'd0, 1'b1, 3'd0, 2'b00, 1'b1, {16'(12 + k), 64'(1001 + k)});
    chk("full_drained", 80'(stat0), 80'd0);

    irq_en = 2'b10;
    step(2'b11, 16'h000a, 16'h000b, 64'h1234, 1'b0, 3'd0, 2'b00, 1'b0, 80'd0);
    chk("multi_stat", 80'(stat0), 80'h0101);
    chk("multi_irq_set", 80'(irq0), 80'd1);
    step(2'b00, 16'd0, 16'd0, 64'd0, 1'b1, 3'd1, 2'b00, 1'b1, {16'h000b, 64'h1234});
    chk("multi_irq_ch1_empty", 80'(irq0), 80'd0);
    chk("multi_stat_ch0_left", 80'(stat0), 80'h0001);
    step(2'b00, 16'd0, 16'd0, 64'd0, 1'b1, 3'd0, 2'b00, 1'b1, {16'h000a, 64'h1234});
    chk("multi_irq_stays_low", 80'(irq0), 80'd0);

    irq_en = 2'b01;
    step(2'b01, 16'h0042, 16'd0, 64'd77, 1'b0, 3'd0, 2'b00, 1'b0, 80'd0);
    chk("midrst_stat_before", 80'(stat0), 80'h0001);
    chk("midrst_irq_before", 80'(irq0), 80'd1);
    rst = 1'b0;
    #1;
    chk("midrst_stat_async", 80'(stat0), 80'd0);
    chk("midrst_irq_async", 80'(irq0), 80'd0);
    chk("midrst_rd_data", rd_data0, 80'd0);
    @(negedge clk);
    rst = 1'b1;
    step(2'b00, 16'd0, 16'd0, 64'd0, 1'b1, 3'd0, 2'b00, 1'b0, 80'd0);
    chk("midrst_pop_empty", 80'(rd_valid0), 80'd0);

    chk("sb_drained", 80'(sb.size()), 80'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/tsu_queue_mc.md
# tsu_queue_mc

Multi-channel timestamp queue that generalises the fixed rx/tx pair of per-port timestamp queues into one parametrised block. It serves CH capture channels. Each channel has its own FIFO of DEPTH entries, and each entry holds the RTC time sampled at a capture strobe together with a 16-bit tag. A single register-side read port drains any channel with 1-cycle latency. Sits between the RTC/TSU capture logic and the register file, all in one clock domain; any CDC is done upstream.

## Interface
- CH, 2: number of capture channels, 1..8.
- DEPTH, 16: entries per channel; power of two, 2..32.
- TS_W, 64: timestamp width in bits.
- OVF_MODE, 0: overflow policy. 0 = drop the new entry; 1 = overwrite the oldest entry.
- clk  input  1  block clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rtc_time_in  input  TS_W  current RTC time; already in clk domain.
- cap_valid_in  input  CH  per-channel capture strobe; bit i high for one cycle = one capture.
- cap_tag_in  input  16*CH  per-channel tag; channel i uses bits [16i+15:16i].
- rd_ch_in  input  3  channel to read.
- rd_en_in  input  1  pop request for channel rd_ch_in.
- rd_data_out  output  TS_W+16  popped entry, {tag, time}.
- rd_valid_out  output  1  rd_data_out holds a fresh entry this cycle.
- stat_out  output  8*CH  per-channel status byte: [7] sticky overflow, [6] 0, [5:0] entry count.
- ovf_clr_in  input  CH  clears the sticky overflow bit of channel i.
- irq_en_in  input  CH  per-channel interrupt enable.
- irq_out  output  1  OR over i of (irq_en_in[i] & count_i != 0); registered.

## Operation
- Each channel keeps: storage of DEPTH x (TS_W+16), a write pointer, a read pointer (both log2(DEPTH) bits, wrapping modulo DEPTH), a count (0..DEPTH) and a sticky overflow flag.
- Capture: when cap_valid_in[i]=1 in cycle n, entry {cap_tag_in[i], rtc_time_in sampled in cycle n} is written.
  - Channels capture independently.
  - Several channels may capture in the same cycle; all of them store the identical time.
- Pop: when rd_en_in=1, rd_ch_in<CH and count>0, the entry at the read pointer is output, then the read pointer advances and count decrements.
  - rd_ch_in>=CH, or an empty channel: no state change, and rd_valid_out stays 0.
- Push and pop on the same channel in the same cycle: both take effect.
  - Count is unchanged.
  - Allowed when empty? No: a pop of an empty channel is ignored even when a push happens that cycle.
  - When full, the pop frees a slot, the push is accepted, and no overflow is flagged.
- Push into a full channel (no simultaneous pop):
  - OVF_MODE=0: entry discarded, ovf set, pointers and count unchanged.
  - OVF_MODE=1: entry written at the write pointer, both pointers advance (oldest lost), count stays DEPTH, ovf set.
- ovf_clr_in[i] clears ovf_i. If an overflow occurs in the same cycle, set wins.
- Count/status arithmetic saturates at neither end; invariants are 0<=count<=DEPTH and wp-rp ≡ count mod DEPTH.

## Timing
- Reset (rst=0, async): all pointers, counts and ovf flags 0; rd_data_out=0, rd_valid_out=0, irq_out=0, stat_out=0.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all queued entries immediately.
- Capture at edge n: stat_out count and irq_out reflect the entry after edge n, i.e. visible in cycle n+1.
- Read latency is 1 cycle: rd_en_in accepted at edge n gives rd_data_out valid and rd_valid_out=1 during cycle n+1.
  - rd_valid_out is a single-cycle pulse per pop.
  - rd_data_out holds its last value otherwise.
- Back-to-back pops (rd_en_in high on consecutive cycles) return consecutive entries, one per cycle, with no bubbles.
- A capture on the channel being read in cycle n is poppable from cycle n+1 (no write-to-read bypass in the same cycle).

## Test plan
- Reset then idle: all outputs 0; stat_out=0 for every channel, irq_out=0.
- Ordering, CH=2, DEPTH=4: capture ch0 with tags 1,2,3 at rtc_time_in 100,200,300, then pop ch0 three times back-to-back -> rd_data_out {1,100},{2,200},{3,300} in consecutive cycles; count goes 3->0; a 4th pop gives rd_valid_out=0.
- Overflow OVF_MODE=0: 5 captures into ch1 (tags 1..5) -> count=4, stat bit7=1, pops return tags 1..4; ovf_clr_in[1] pulse -> bit7=0. Repeat with OVF_MODE=1 -> pops return tags 2..5.
- Simultaneous push+pop on full ch0 (DEPTH=4) -> count stays 4, ovf stays 0, popped entry is the oldest.
- Multi-channel: cap_valid_in=2'b11 with rtc_time_in=0x1234 -> both channels hold time 0x1234; irq_en_in=2'b10 -> irq_out=1 while ch1 is non-empty, 0 after ch1 is drained even though ch0 is non-empty.
- rd_ch_in=5 with CH=2 and rd_en_in=1 -> no state change, rd_valid_out=0.
